// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}; consumers apply board polarity.
// Contents: SEG_0..SEG_F hex glyphs, SEG_BLANK, SEG_NUM_DIGITS (digits per scan frame).
package seg_pkg;

  localparam int unsigned SEG_NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to seven-segment glyph decoder (active-high).
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_seg     out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment scanner with double-buffered display value.
// One digit advance per rising edge of Tick_in; new data is swapped in only at the
// frame wrap (digit 3 -> 0) so a frame never mixes old and new digits.
// Ports:
//   Clk_in, Rst (async, active-high)
//   Tick_in           refresh square wave (Clk_in domain)
//   Load/Data_in/Dp_in capture strobe and value for the pending buffer
//   An/Seg/Dp         registered display drive at SEG_ACTIVE level
//   Pending           loaded value waiting for frame wrap
//   Frame_done        1-cycle pulse on wrap
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits 3..1.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = SEG_NUM_DIGITS,
  parameter bit          SEG_ACTIVE = 1'b0
) (
  input  logic        Clk_in,
  input  logic        Rst,
  input  logic        Tick_in,
  input  logic        Load,
  input  logic [15:0] Data_in,
  input  logic [3:0]  Dp_in,
  output logic [3:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Pending,
  output logic        Frame_done
);

  localparam logic [1:0] LastIdx = 2'(NUM_DIGITS - 1);
  localparam logic [3:0] AnOff   = {4{~SEG_ACTIVE}};
  localparam logic [6:0] SegOff  = {7{~SEG_ACTIVE}};

  logic        r_tick_d;
  logic [1:0]  r_idx;
  logic [15:0] r_disp;
  logic [3:0]  r_disp_dp;
  logic [15:0] r_pend;
  logic [3:0]  r_pend_dp;
  logic        r_pending;
  logic        r_frame_done;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_step;
  logic        w_wrap;
  logic [1:0]  w_idx_n;
  logic [15:0] w_disp_n;
  logic [3:0]  w_disp_dp_n;
  logic        w_pending_n;
  logic [3:0]  w_nibble;
  logic [6:0]  w_glyph;
  logic [6:0]  w_glyph_shown;
  logic        w_blank;
  logic [3:0]  w_an_hot;

  always_comb begin
    w_step      = Tick_in & ~r_tick_d;
    w_wrap      = w_step & (r_idx == LastIdx);
    w_idx_n     = w_step ? r_idx + 2'd1 : r_idx;
    w_disp_n    = r_disp;
    w_disp_dp_n = r_disp_dp;
    w_pending_n = Load ? 1'b1 : r_pending;
    if (w_wrap) begin
      // A load on the wrapping cycle bypasses the pending buffer entirely.
      if (Load) begin
        w_disp_n    = Data_in;
        w_disp_dp_n = Dp_in;
      end else if (r_pending) begin
        w_disp_n    = r_pend;
        w_disp_dp_n = r_pend_dp;
      end
      w_pending_n = 1'b0;
    end
  end

  // Outputs are built from the post-step index and buffer so digit 0 shows new data at wrap.
  always_comb begin
    w_nibble = w_disp_n[3:0];
    unique case (w_idx_n)
      2'd0: w_nibble = w_disp_n[3:0];
      2'd1: w_nibble = w_disp_n[7:4];
      2'd2: w_nibble = w_disp_n[11:8];
      2'd3: w_nibble = w_disp_n[15:12];
    endcase
  end

  always_comb begin
    w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (w_idx_n)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = (w_disp_n[15:4] == 12'h0) && !w_disp_dp_n[1];
      2'd2: w_blank = (w_disp_n[15:8] == 8'h0) && !w_disp_dp_n[2];
      2'd3: w_blank = (w_disp_n[15:12] == 4'h0) && !w_disp_dp_n[3];
    endcase
`endif
  end

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  assign w_glyph_shown = w_blank ? SEG_BLANK : w_glyph;
  assign w_an_hot      = 4'b0001 << w_idx_n;

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      r_tick_d     <= 1'b0;
      r_idx        <= 2'd0;
      r_disp       <= 16'h0;
      r_disp_dp    <= 4'h0;
      r_pend       <= 16'h0;
      r_pend_dp    <= 4'h0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= AnOff;
      r_seg        <= SegOff;
      r_dp         <= ~SEG_ACTIVE;
    end else begin
      r_tick_d     <= Tick_in;
      r_frame_done <= w_wrap;
      r_idx        <= w_idx_n;
      r_disp       <= w_disp_n;
      r_disp_dp    <= w_disp_dp_n;
      r_pending    <= w_pending_n;
      if (Load) begin
        r_pend    <= Data_in;
        r_pend_dp <= Dp_in;
      end
      if (w_step) begin
        r_an  <= SEG_ACTIVE ? w_an_hot : ~w_an_hot;
        r_seg <= SEG_ACTIVE ? w_glyph_shown : ~w_glyph_shown;
        r_dp  <= SEG_ACTIVE ? w_disp_dp_n[w_idx_n] : ~w_disp_dp_n[w_idx_n];
      end
    end
  end

  assign An         = r_an;
  assign Seg        = r_seg;
  assign Dp         = r_dp;
  assign Pending    = r_pending;
  assign Frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (default parameters: active-low drive).
module tb_seven_seg_scanner;

  logic        Clk_in = 1'b0;
  logic        Rst = 1'b1;
  logic        Tick_in = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Data_in = 16'h0;
  logic [3:0]  Dp_in = 4'h0;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        Pending;
  logic        Frame_done;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;

  // Reference glyphs, lit = 1, {g,f,e,d,c,b,a}
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Behavioural model state
  int          m_idx;
  bit          m_lit, m_tick_d, m_pending, m_fd;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;

  seven_seg_scanner dut (
    .Clk_in     (Clk_in),
    .Rst        (Rst),
    .Tick_in    (Tick_in),
    .Load       (Load),
    .Data_in    (Data_in),
    .Dp_in      (Dp_in),
    .An         (An),
    .Seg        (Seg),
    .Dp         (Dp),
    .Pending    (Pending),
    .Frame_done (Frame_done)
  );

  always #5 Clk_in = ~Clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_lit = 0; m_tick_d = 0; m_pending = 0; m_fd = 0;
    m_disp = 16'h0; m_pend = 16'h0; m_ddp = 4'h0; m_pdp = 4'h0;
  endtask

  task automatic model_clock();
    bit step, wrap;
    step = Tick_in && !m_tick_d;
    m_tick_d = Tick_in;
    wrap = step && (m_idx == 3);
    m_fd = wrap;
    if (wrap) begin
      if (Load) begin
        m_disp = Data_in; m_ddp = Dp_in;
      end else if (m_pending) begin
        m_disp = m_pend; m_ddp = m_pdp;
      end
      m_pending = 0;
    end else if (Load) begin
      m_pend = Data_in; m_pdp = Dp_in; m_pending = 1;
    end
    if (step) begin
      m_idx = (m_idx + 1) % 4;
      m_lit = 1;
    end
  endtask

  task automatic model_compare();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         nib;
    bit         blank;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_lit) begin
      nib   = int'((m_disp >> (4 * m_idx)) & 16'hF);
      blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (m_idx >= 1) && ((m_disp >> (4 * m_idx)) == 16'h0) && !m_ddp[m_idx];
`endif
      e_an  = ~(4'b0001 << m_idx);
      e_seg = blank ? 7'h7F : ~glyph_tab[nib];
      e_dp  = ~m_ddp[m_idx];
    end
    chk("an", 32'(An), 32'(e_an));
    chk("seg", 32'(Seg), 32'(e_seg));
    chk("dp", 32'(Dp), 32'(e_dp));
    chk("pending", 32'(Pending), 32'(m_pending));
    chk("frame_done", 32'(Frame_done), 32'(m_fd));
  endtask

  task automatic cyc();
    @(posedge Clk_in);
    model_clock();
    #1;
    if (Frame_done === 1'b1) fd_count++;
    model_compare();
  endtask

  task automatic step_once();
    Tick_in = 1'b1; cyc();
    Tick_in = 1'b0; cyc();
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 4 && m_idx != target; i++) step_once();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    Load = 1'b1; Data_in = d; Dp_in = p;
    cyc();
    Load = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge Clk_in);
    #1;
    chk("reset_an", 32'(An), 32'h0F);
    chk("reset_seg", 32'(Seg), 32'h7F);
    chk("reset_dp", 32'(Dp), 32'h1);
    chk("reset_pending", 32'(Pending), 32'h0);
    chk("reset_fd", 32'(Frame_done), 32'h0);
    Rst = 1'b0;
    cyc();

    // Load then scan one full frame up to wrap, then walk the new frame
    do_load(16'h12AF, 4'h0);
    chk("t2_pending", 32'(Pending), 32'h1);
    repeat (4) step_once();
    chk("t2_an0", 32'(An), 32'hE);
    chk("t2_seg0", 32'(Seg), 32'h0E);
    chk("t2_pend_clr", 32'(Pending), 32'h0);
    step_once();
    chk("t2_an1", 32'(An), 32'hD);
    chk("t2_seg1", 32'(Seg), 32'h08);
    step_once();
    chk("t2_an2", 32'(An), 32'hB);
    chk("t2_seg2", 32'(Seg), 32'h24);
    step_once();
    chk("t2_an3", 32'(An), 32'h7);
    chk("t2_seg3", 32'(Seg), 32'h79);

    // Tick held high: one advance only (idx 3 -> 0)
    Tick_in = 1'b1;
    repeat (50) cyc();
    chk("t3_held_an", 32'(An), 32'hE);
    Tick_in = 1'b0;
    cyc();
    fd_count = 0;
    repeat (8) step_once();
    chk("t3_fd_count", 32'(fd_count), 32'd2);

    // Async reset mid-scan with a pending load
    step_once();
    do_load(16'h1234, 4'hF);
    chk("t1_pending_before", 32'(Pending), 32'h1);
    #2 Rst = 1'b1;
    #1;
    chk("t1_an", 32'(An), 32'h0F);
    chk("t1_seg", 32'(Seg), 32'h7F);
    chk("t1_pending", 32'(Pending), 32'h0);
    model_reset();
    @(posedge Clk_in);
    #1 Rst = 1'b0;
    cyc();
    repeat (4) step_once();
    chk("t1_discarded", 32'(Seg), 32'h40);

    // Last load before wrap wins
    do_load(16'h0001, 4'h0);
    do_load(16'h0002, 4'h0);
    step_to(3);
    chk("t4_pending_hold", 32'(Pending), 32'h1);
    step_once();
    chk("t4_seg", 32'(Seg), 32'h24);
    chk("t4_pending", 32'(Pending), 32'h0);

    // Load coinciding with the wrapping step bypasses pending buffer
    step_to(3);
    Tick_in = 1'b1; Load = 1'b1; Data_in = 16'hBEEF; Dp_in = 4'h1;
    cyc();
    Load = 1'b0;
    chk("t5_an", 32'(An), 32'hE);
    chk("t5_seg", 32'(Seg), 32'h0E);
    chk("t5_dp", 32'(Dp), 32'h0);
    chk("t5_pending", 32'(Pending), 32'h0);
    Tick_in = 1'b0;
    cyc();

    // Leading-zero handling
    do_load(16'h0050, 4'h0);
    step_to(3);
    step_once();
    chk("t6_d0", 32'(Seg), 32'h40);
    step_once();
    chk("t6_d1", 32'(Seg), 32'h12);
    step_once();
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_d2", 32'(Seg), 32'h7F);
`else
    chk("t6_d2", 32'(Seg), 32'h40);
`endif
    chk("t6_an2", 32'(An), 32'hB);
    step_once();
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_d3", 32'(Seg), 32'h7F);
`else
    chk("t6_d3", 32'(Seg), 32'h40);
`endif

    // Random ticks and loads against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) Tick_in = ~Tick_in;
      Load = ($urandom_range(0, 9) == 0);
      Data_in = 16'($urandom);
      Dp_in = 4'($urandom);
      if (($urandom_range(0, 3) == 0) && (i % 2 == 0)) Data_in[15:8] = 8'h00;
      cyc();
    end
    Load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
